seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter W SHALL default to 4 and sets the pattern width in bits (legal range 2..16).
REQ-002 Parameter DEF_PATTERN SHALL default to 4'b1010 and is the pattern loaded into the shift register at reset.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: request a transmission; sampled only when ready=1.
REQ-006 Port pattern SHALL be an input, W bits: pattern to send, MSB first; captured on an accepted start.
REQ-007 Port reps SHALL be an input, 8 bits: number of back-to-back pattern repetitions; captured on an accepted start.
REQ-008 Port ready SHALL be an output, 1 bit: high only in IDLE.
REQ-009 Port out SHALL be an output, 1 bit: the serial data bit.
REQ-010 Port out_valid SHALL be an output, 1 bit: high when out carries a pattern bit.
REQ-011 Port done SHALL be an output, 1 bit: one-cycle pulse when a transmission completes.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE, encoded by a package enum.
REQ-013 IDLE with start=1 SHALL capture pattern and reps and go to SHIFT, or go to DONE if reps=0.
REQ-014 In SHIFT, the first out bit SHALL appear the cycle after start is accepted (latency 1), with out_valid=1.
REQ-015 SHIFT SHALL emit W bits MSB first, one per cycle, using a bit counter from W-1 down to 0.
REQ-016 At bit index 0, if repetitions remain, the FSM SHALL reload the captured pattern and continue with no idle cycle (or enter GAP, see REQ-024).
REQ-017 At bit index 0 of the last repetition, the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, out=0 and out_valid=0, then return to IDLE.
REQ-019 start asserted while ready=0 SHALL be ignored and not queued; changes to pattern or reps while busy SHALL have no effect.
REQ-020 In every state other than SHIFT, out SHALL be 0 and out_valid SHALL be 0.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-022 When rst=0, the block SHALL asynchronously force state=IDLE, ready=1, out=0, out_valid=0, done=0, both counters to 0 and the shift register to DEF_PATTERN.
REQ-023 Reset asserted mid-transmission SHALL abort it immediately, with no done pulse; the first start after reset release begins a fresh transmission.

Configuration
REQ-024 With SEQ_GEN_GAP_EN defined, the block SHALL have a 4-bit input gap, captured on start, and insert gap idle cycles (GAP state, out_valid=0) between repetitions but not after the last; gap=0 behaves as back-to-back.
REQ-025 Without SEQ_GEN_GAP_EN, the gap port and the GAP state logic SHALL be absent and repetitions SHALL always be back-to-back.

Structure
REQ-026 Package seq_gen_pkg SHALL hold the state enum, DEF_PATTERN default constant, and REPS_W=8 / GAP_W=4 width constants.
REQ-027 The block SHALL be a single module with no sub-module; the FSM, shift register, bit counter, repetition counter and gap counter all live in seq_pattern_gen.

Verification
REQ-028 The bench SHALL check reset: rst=0 mid-SHIFT -> out=0, out_valid=0, ready=1 the same cycle, no done pulse.
REQ-029 The bench SHALL check a single repetition: pattern=1010, reps=1, start for 1 cycle -> out=1,0,1,0 on cycles 1-4 with out_valid=1, done on cycle 5, ready on cycle 6.
REQ-030 The bench SHALL check back-to-back repetitions: pattern=1010, reps=3 -> 12 contiguous valid bits 101010101010; an overlapping 1010 checker fires 5 times.
REQ-031 The bench SHALL check reps=0: start -> no valid bits, done on cycle 1, ready again on cycle 2.
REQ-032 The bench SHALL check busy start: start held high for 10 cycles with pattern changing to 0110 at cycle 2 and reps=1 -> only 1010 is sent, then a second transmission of 0110 starts the cycle after ready returns.
REQ-033 The bench SHALL check the gap (SEQ_GEN_GAP_EN defined): pattern=1010, reps=2, gap=3 -> 1010, then 3 cycles with out_valid=0, then 1010, then done.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_gen_pkg;

    localparam int REPS_W = 8;
    localparam int GAP_W  = 4;

    localparam logic [3:0] DEF_PATTERN = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends a W-bit pattern MSB first, reps times back-to-back.
// Define SEQ_GEN_GAP_EN to add the gap input and idle cycles between repetitions.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// SHIFT | out carries one pattern bit per cycle
// GAP   | idle cycles between repetitions (SEQ_GEN_GAP_EN only)
// DONE  | one-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
    parameter int           W           = 4,
    parameter logic [W-1:0] DEF_PATTERN = W'(seq_gen_pkg::DEF_PATTERN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [W-1:0]                    pattern,
    input  logic [seq_gen_pkg::REPS_W-1:0]  reps,
`ifdef SEQ_GEN_GAP_EN
    input  logic [seq_gen_pkg::GAP_W-1:0]   gap,
`endif
    output logic                            ready,
    output logic                            out,
    output logic                            out_valid,
    output logic                            done
);

    import seq_gen_pkg::*;

    localparam int             CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    state_e              state_q,     state_d;
    logic [W-1:0]        shreg_q,     shreg_d;
    logic [W-1:0]        pat_q,       pat_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [REPS_W-1:0]   rep_cnt_q,   rep_cnt_d;
    logic                ready_q,     ready_d;
    logic                out_q,       out_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q,      done_d;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0]    gap_len_q,   gap_len_d;
    logic [GAP_W-1:0]    gap_cnt_q,   gap_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pat_d       = pat_q;
        bit_cnt_d   = bit_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        ready_d     = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    ready_d = 1'b0;
                    pat_d   = pattern;
                    shreg_d = pattern;
`ifdef SEQ_GEN_GAP_EN
                    gap_len_d = gap;
`endif
                    if (reps == '0) begin
                        rep_cnt_d = '0;
                        state_d   = DONE;
                        done_d    = 1'b1;
                    end else begin
                        rep_cnt_d   = reps - REPS_W'(1);
                        bit_cnt_d   = LAST_BIT;
                        state_d     = SHIFT;
                        out_valid_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    // rotate so every register bit stays live; MSB is the next bit out
                    shreg_d     = {shreg_q[W-2:0], shreg_q[W-1]};
                    bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                    out_valid_d = 1'b1;
                end else if (rep_cnt_q != '0) begin
                    rep_cnt_d = rep_cnt_q - REPS_W'(1);
`ifdef SEQ_GEN_GAP_EN
                    if (gap_len_q != '0) begin
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                        state_d   = GAP;
                    end else begin
`else
                    begin
`endif
                        shreg_d     = pat_q;
                        bit_cnt_d   = LAST_BIT;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end

`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (gap_cnt_q == '0) begin
                    shreg_d     = pat_q;
                    bit_cnt_d   = LAST_BIT;
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        out_d = out_valid_d & shreg_d[W-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= DEF_PATTERN;
            pat_q       <= DEF_PATTERN;
            bit_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            ready_q     <= 1'b1;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pat_q       <= pat_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SEQ_GEN_GAP_EN
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; gap sequences run when SEQ_GEN_GAP_EN is defined.
`timescale 1ns/1ps
module tb_seq_pattern_gen;
    import seq_gen_pkg::*;

    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      pattern = '0;
    logic [REPS_W-1:0] reps = '0;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0]  gap = '0;
`endif
    logic              ready, out, out_valid, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] pat;
        int         reps;
        int         exp_stream;
        int         exp_len;
        int         exp_done;
        int         exp_hits;
    } vec_t;

    seq_pattern_gen #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
`ifdef SEQ_GEN_GAP_EN
        .gap       (gap),
`endif
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One start pulse, then collect until done; cycle k is k clocks after the accepting edge.
    task automatic run_txn(input logic [3:0] p, input int r,
                           output int stream, output int len, output int done_cyc,
                           output int idle, output int hits, output int zviol,
                           output int rdy_after);
        logic [3:0] win;
        stream = 0; len = 0; done_cyc = -1; idle = 0; hits = 0; zviol = 0; rdy_after = 0;
        win = '0;
        @(negedge clk);
        pattern = p;
        reps    = REPS_W'(r);
        start   = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                stream = (stream << 1) | int'(out);
                len++;
                win = {win[2:0], out};
                if (len >= 4 && win == 4'b1010) hits++;
            end else begin
                if (out) zviol++;
                if (!done) idle++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        @(negedge clk);
        rdy_after = int'(ready);
    endtask

    initial begin
        vec_t v[6];
        int s, l, d, idl, h, z, ra;
        int done_seen, valid_seen;
        int d1, d2, rdy_cyc, second_start, after_valid;

        v[0] = '{4'b1010, 1, 'hA,   4,  5,  1};
        v[1] = '{4'b1010, 3, 'hAAA, 12, 13, 5};
        v[2] = '{4'b0110, 2, 'h66,  8,  9,  0};
        v[3] = '{4'b1111, 1, 'hF,   4,  5,  0};
        v[4] = '{4'b0001, 2, 'h11,  8,  9,  0};
        v[5] = '{4'b0000, 0, 0,     0,  1,  0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(v[i].pat, v[i].reps, s, l, d, idl, h, z, ra);
            check($sformatf("v%0d_stream", i), s, v[i].exp_stream);
            check($sformatf("v%0d_len", i), l, v[i].exp_len);
            check($sformatf("v%0d_done_cyc", i), d, v[i].exp_done);
            check($sformatf("v%0d_hits", i), h, v[i].exp_hits);
            check($sformatf("v%0d_idle", i), idl, 0);
            check($sformatf("v%0d_out_when_invalid", i), z, 0);
            check($sformatf("v%0d_ready_after", i), ra, 1);
        end

        // reset asserted mid-SHIFT
        @(negedge clk);
        pattern = 4'b1010;
        reps    = 8'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_valid_before_rst", int'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_done", int'(done), 0);
        done_seen  = 0;
        valid_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (out_valid) valid_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        check("mid_rst_no_resume", valid_seen, 0);
        run_txn(4'b1010, 1, s, l, d, idl, h, z, ra);
        check("post_rst_stream", s, 'hA);
        check("post_rst_done_cyc", d, 5);

        // start held while busy, pattern changed mid-transmission
        @(negedge clk);
        pattern = 4'b1010;
        reps    = 8'd1;
        start   = 1'b1;
        s = 0; l = 0; d1 = -1; d2 = -1; rdy_cyc = -1; second_start = -1; after_valid = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) pattern = 4'b0110;
            if (k == 10) start = 1'b0;
            if (out_valid) begin
                s = (s << 1) | int'(out);
                l++;
                if (d2 >= 0) after_valid++;
                if (d1 >= 0 && second_start < 0) second_start = k;
            end
            if (ready && d1 >= 0 && rdy_cyc < 0) rdy_cyc = k;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        check("busy_stream", s, 'hA6);
        check("busy_len", l, 8);
        check("busy_done1", d1, 5);
        check("busy_ready", rdy_cyc, 6);
        check("busy_second_start", second_start, 7);
        check("busy_done2", d2, 11);
        check("busy_no_third", after_valid, 0);

`ifdef SEQ_GEN_GAP_EN
        gap = 4'd3;
        run_txn(4'b1010, 2, s, l, d, idl, h, z, ra);
        check("gap3_stream", s, 'hAA);
        check("gap3_len", l, 8);
        check("gap3_idle", idl, 3);
        check("gap3_done_cyc", d, 12);
        check("gap3_out_when_invalid", z, 0);
        gap = 4'd0;
        run_txn(4'b1010, 2, s, l, d, idl, h, z, ra);
        check("gap0_idle", idl, 0);
        check("gap0_done_cyc", d, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
